rx_gasket: RTL and testbench

Receive-side width gasket of the PHY, the counterpart to the transmit gasket. It takes the decoded 8-bit symbol stream (data byte plus K flag) in the symbol-rate clock domain, one symbol per cycle. It packs consecutive symbols into 8-, 16- or 32-bit MAC words, selected by DataBusWidth, and presents each completed word with a one-cycle valid strobe. It sits between the 8b/10b decoder and the MAC-side receive interface.

---
 rtl/rx_gasket.sv | 195 +++++++++++++++++++
 tb/tb_rx_gasket.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/rx_gasket.sv
// Receive width gasket: packs decoded 8-bit symbols into 8/16/32-bit MAC words.
// Optional macro COMMA_ALIGN_EN re-aligns words on a K28.5 comma seen mid-word.
module rx_gasket (
  input  logic        Bit_Rate_CLK_10,
  input  logic        Reset,
  input  logic [5:0]  DataBusWidth,
  input  logic [7:0]  RxData,
  input  logic        RxDataK,
  input  logic        RxValid,
  output logic [31:0] MAC_RX_Data,
  output logic [3:0]  MAC_RX_DataK,
  output logic        MAC_RX_Valid,
  output logic        Partial_Drop
);

`ifdef COMMA_ALIGN_EN
  localparam logic [7:0] COM_SYMBOL = 8'hBC;
`endif

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [1:0]  last_q, last_d;
  logic [31:0] stage_data_q, stage_data_d;
  logic [3:0]  stage_k_q, stage_k_d;
  logic [31:0] data_q, data_d;
  logic [3:0]  datak_q, datak_d;
  logic        valid_q, valid_d;
  logic        drop_q, drop_d;

  logic [1:0]  new_last_s;
  logic [31:0] lane_data_s;
  logic [3:0]  lane_k_s;
  logic        begin_word_s;
  logic        align_hit_s;

  // Index of the last byte lane for a given bus width; unknown widths act as 8.
  function automatic logic [1:0] width_to_last(input logic [5:0] width);
    logic [1:0] last;
    case (width)
      6'd16:   last = 2'd1;
      6'd32:   last = 2'd3;
      default: last = 2'd0;
    endcase
    return last;
  endfunction

  function automatic logic [31:0] data_mask(input logic [1:0] last);
    logic [31:0] mask;
    case (last)
      2'd0:    mask = 32'h0000_00FF;
      2'd1:    mask = 32'h0000_FFFF;
      default: mask = 32'hFFFF_FFFF;
    endcase
    return mask;
  endfunction

  function automatic logic [3:0] k_mask(input logic [1:0] last);
    logic [3:0] mask;
    case (last)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    return mask;
  endfunction

  // Staging contents with the incoming symbol merged into the current lane.
  always_comb begin
    lane_data_s = stage_data_q;
    lane_k_s    = stage_k_q;
    new_last_s  = width_to_last(DataBusWidth);
    lane_data_s[{idx_q, 3'b000} +: 8] = RxData;
    lane_k_s[idx_q] = RxDataK;
  end

  // Comma detection for realignment; compiled out when alignment is disabled.
  always_comb begin
`ifdef COMMA_ALIGN_EN
    if (RxDataK && (RxData == COM_SYMBOL) && (idx_q != 2'd0)) begin
      align_hit_s = 1'b1;
    end else begin
      align_hit_s = 1'b0;
    end
`else
    align_hit_s = 1'b0;
`endif
  end

  // Next-state, staging and output computation.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    last_d       = last_q;
    stage_data_d = stage_data_q;
    stage_k_d    = stage_k_q;
    data_d       = data_q;
    datak_d      = datak_q;
    valid_d      = 1'b0;
    drop_d       = 1'b0;
    begin_word_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (RxValid) begin
          begin_word_s = 1'b1;
        end else begin
          idx_d = 2'd0;
        end
      end
      ST_COLLECT: begin
        if (!RxValid) begin
          drop_d       = 1'b1;
          idx_d        = 2'd0;
          stage_data_d = 32'h0000_0000;
          stage_k_d    = 4'b0000;
          state_d      = ST_IDLE;
        end else if (align_hit_s) begin
          drop_d       = 1'b1;
          begin_word_s = 1'b1;
        end else if (idx_q == last_q) begin
          data_d       = lane_data_s & data_mask(last_q);
          datak_d      = lane_k_s & k_mask(last_q);
          valid_d      = 1'b1;
          stage_data_d = lane_data_s;
          stage_k_d    = lane_k_s;
          idx_d        = 2'd0;
          state_d      = ST_IDLE;
        end else begin
          stage_data_d = lane_data_s;
          stage_k_d    = lane_k_s;
          idx_d        = idx_q + 2'd1;
        end
      end
      default: begin
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end
    endcase

    // A new word starts with lanes cleared so shorter words carry no stale bytes.
    if (begin_word_s) begin
      last_d       = new_last_s;
      stage_data_d = {24'h00_0000, RxData};
      stage_k_d    = {3'b000, RxDataK};
      if (new_last_s == 2'd0) begin
        data_d  = {24'h00_0000, RxData};
        datak_d = {3'b000, RxDataK};
        valid_d = 1'b1;
        idx_d   = 2'd0;
        state_d = ST_IDLE;
      end else begin
        idx_d   = 2'd1;
        state_d = ST_COLLECT;
      end
    end else begin
      last_d = last_d;
    end
  end

  // State, staging and registered outputs.
  always_ff @(posedge Bit_Rate_CLK_10 or posedge Reset) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      idx_q        <= 2'd0;
      last_q       <= 2'd0;
      stage_data_q <= 32'h0000_0000;
      stage_k_q    <= 4'b0000;
      data_q       <= 32'h0000_0000;
      datak_q      <= 4'b0000;
      valid_q      <= 1'b0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      last_q       <= last_d;
      stage_data_q <= stage_data_d;
      stage_k_q    <= stage_k_d;
      data_q       <= data_d;
      datak_q      <= datak_d;
      valid_q      <= valid_d;
      drop_q       <= drop_d;
    end
  end

  assign MAC_RX_Data  = data_q;
  assign MAC_RX_DataK = datak_q;
  assign MAC_RX_Valid = valid_q;
  assign Partial_Drop = drop_q;

endmodule

// File: tb/tb_rx_gasket.sv
// Directed scoreboard bench for rx_gasket; honours COMMA_ALIGN_EN if defined.
module tb_rx_gasket;

  logic        clk;
  logic        rst;
  logic [5:0]  width;
  logic [7:0]  rx_data;
  logic        rx_k;
  logic        rx_valid;
  logic [31:0] mac_data;
  logic [3:0]  mac_k;
  logic        mac_valid;
  logic        drop;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
  } word_t;

  word_t sb[$];
  int compared   = 0;
  int mismatched = 0;

  rx_gasket dut (
    .Bit_Rate_CLK_10 (clk),
    .Reset           (rst),
    .DataBusWidth    (width),
    .RxData          (rx_data),
    .RxDataK         (rx_k),
    .RxValid         (rx_valid),
    .MAC_RX_Data     (mac_data),
    .MAC_RX_DataK    (mac_k),
    .MAC_RX_Valid    (mac_valid),
    .Partial_Drop    (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k);
    word_t w;
    w.d = d;
    w.k = k;
    sb.push_back(w);
  endtask

  // Drive one symbol, sample #1 after the edge, check strobes and pop on a word.
  task automatic step(input logic [7:0] d, input logic k, input logic v,
                      input logic exp_valid, input logic exp_drop);
    word_t w;
    rx_data  = d;
    rx_k     = k;
    rx_valid = v;
    @(posedge clk);
    #1;
    chk("valid", {31'd0, mac_valid}, {31'd0, exp_valid});
    chk("drop", {31'd0, drop}, {31'd0, exp_drop});
    if (mac_valid) begin
      if (sb.size() > 0) begin
        w = sb.pop_front();
        chk("data", mac_data, w.d);
        chk("datak", {28'd0, mac_k}, {28'd0, w.k});
      end else begin
        chk("sb_underflow", 32'd1, {31'd0, 1'b0} + 32'(sb.size()));
      end
    end
  endtask

  task automatic drained(input string tag);
    chk(tag, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    rst      = 1'b1;
    width    = 6'd8;
    rx_data  = 8'h00;
    rx_k     = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", mac_data, 32'h0);
    chk("rst_datak", {28'd0, mac_k}, 32'h0);
    chk("rst_valid", {31'd0, mac_valid}, 32'h0);
    chk("rst_drop", {31'd0, drop}, 32'h0);
    rst = 1'b0;

    // 8-bit words back to back
    push(32'h0000_0011, 4'b0000);
    step(8'h11, 1'b0, 1'b1, 1'b1, 1'b0);
    push(32'h0000_0022, 4'b0000);
    step(8'h22, 1'b0, 1'b1, 1'b1, 1'b0);
    push(32'h0000_0033, 4'b0000);
    step(8'h33, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drained("sb_w8");

    // 32-bit word, K on byte 0, strobe only after the fourth byte
    width = 6'd32;
    push(32'h0403_0201, 4'b0001);
    step(8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h04, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drained("sb_w32");

    // 16-bit word broken by a valid gap
    width = 6'd16;
    step(8'hAA, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    push(32'h0000_CCBB, 4'b0000);
    step(8'hBB, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'hCC, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drained("sb_drop16");

    // Width change mid-word applies to the following word
    width = 6'd32;
    push(32'hA4A3_A2A1, 4'b0000);
    step(8'hA1, 1'b0, 1'b1, 1'b0, 1'b0);
    width = 6'd16;
    step(8'hA2, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'hA3, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'hA4, 1'b0, 1'b1, 1'b1, 1'b0);
    push(32'h0000_B2B1, 4'b0000);
    step(8'hB1, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'hB2, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drained("sb_wchange");

    // Comma in the middle of a 32-bit word
    width = 6'd32;
`ifdef COMMA_ALIGN_EN
    step(8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    push(32'h5040_30BC, 4'b0001);
    step(8'hBC, 1'b1, 1'b1, 1'b0, 1'b1);
    step(8'h30, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h50, 1'b0, 1'b1, 1'b1, 1'b0);
`else
    push(32'h30BC_2010, 4'b0100);
    step(8'h10, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h20, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'hBC, 1'b1, 1'b1, 1'b0, 1'b0);
    step(8'h30, 1'b0, 1'b1, 1'b1, 1'b0);
    push(32'h7060_5040, 4'b0000);
    step(8'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h50, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h60, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h70, 1'b0, 1'b1, 1'b1, 1'b0);
`endif
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drained("sb_comma");

    // Asynchronous reset after three of four bytes
    step(8'h01, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h02, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h03, 1'b0, 1'b1, 1'b0, 1'b0);
    rx_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("arst_data", mac_data, 32'h0);
    chk("arst_datak", {28'd0, mac_k}, 32'h0);
    chk("arst_valid", {31'd0, mac_valid}, 32'h0);
    chk("arst_drop", {31'd0, drop}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    push(32'h0807_0605, 4'b0000);
    step(8'h05, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h06, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h07, 1'b0, 1'b1, 1'b0, 1'b0);
    step(8'h08, 1'b0, 1'b1, 1'b1, 1'b0);
    step(8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    drained("sb_after_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
